harvard_sequencer: RTL and testbench
====================================

# harvard_sequencer

Multi-cycle fetch/decode/execute controller for the Harvard machine. It drives the program counter into the instruction memory, decodes the 22-bit instruction word, and issues the address, data and write enables for the data memory, accumulator and status flag registers. It contains the 16-bit ALU. It sits inside `MEM`, between `Instruction_MEM`, `Data_MEM`, `Accumulator_MEM` and `Status_MEM`.

## Interface
- No parameters; widths are fixed by the memories: PC 8, instruction 22, data 16.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that leaves IDLE.
- `PC` out 8: instruction address.
- `I` in 22: instruction word; combinational read of `PC`.
- `DWA` out 8: data memory address.
- `DW` out 16: data memory write data.
- `DWE` out 1: data memory write enable.
- `DR` in 16: data memory read data; combinational on `DWA`.
- `AW` out 16: accumulator write data.
- `AWE` out 1: accumulator write enable.
- `AR` in 16: accumulator contents.
- `EFW`, `CFW` out 1: registered flag values; `Status_MEM` samples them every cycle.
- `EFF`, `CFF` in 1: flag values from `Status_MEM`.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky; set when an undefined opcode is decoded.

## Operation
- Instruction format:
  - `I[21:16]` opcode.
  - `I[15:0]` immediate.
  - `I[7:0]` address / jump target.
- Opcodes:
  - 0x00 NOP.
  - 0x01 LDI: A=imm.
  - 0x02 LDA: A=M[addr].
  - 0x03 STA: M[addr]=A.
  - 0x04 ADD: A=A+M.
  - 0x05 SUB: A=A−M.
  - 0x06 AND: A=A&M.
  - 0x08 JMP.
  - 0x09 JZ: jump if EFF.
  - 0x0A JC: jump if CFF.
  - 0x0C CALL, 0x0D RET: see Configuration.
  - 0x3F HALT.
  - Any other opcode: `illegal`=1, go to HALT.
- States: IDLE → FETCH → DECODE → EXEC → FETCH …; HALT is terminal.
- IDLE: `PC`=0. Goes to FETCH on `start`; `start` is ignored in every other state.
- FETCH: presents `PC`.
- DECODE: latches `I` into an internal IR. Drives `DWA`=IR[7:0] for the rest of the instruction, so `DR` is valid in EXEC.
- EXEC:
  - Asserts exactly one of `DWE` or `AWE` as the opcode requires, for that one cycle; writes take effect at the end of EXEC.
  - Updates `EFW`/`CFW`.
  - Loads `PC` with the jump target, or with PC+1.
- Arithmetic:
  - ADD: {CF,A} = {1'b0,AR}+{1'b0,DR}.
  - SUB: CF = borrow (AR<DR unsigned); A = AR−DR mod 2^16.
  - AND: CF=0.
  - LDI/LDA: CF unchanged.
  - EF = (new A == 0) for LDI, LDA, ADD, SUB, AND.
  - STA, NOP and jumps leave the flags unchanged.
- Jump conditions use `EFF`/`CFF` sampled in EXEC. These always reflect the previous instruction's flags, because the registered `EFW`/`CFW` reach `Status_MEM` one cycle before the next EXEC.
- PC wraps 0xFF → 0x00 with no error.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC); there is no pipelining.
- Reset values (applied on the first edge with `RST_N`=0, from any state including mid-EXEC):
  - State=IDLE.
  - `PC`=0, `DWA`=0, `DW`=0, `AW`=0.
  - `DWE`=0, `AWE`=0.
  - `EFW`=0, `CFW`=0.
  - `halted`=0, `illegal`=0.
  - Return register=0.
- `DWE`/`AWE` are low in every state except EXEC and are never high together.
- HALT:
  - Entered at the end of the EXEC that decodes HALT or an illegal opcode.
  - `PC` stays at the address of the halting instruction.
  - All enables stay low until reset.
- `start` arriving in the same cycle as reset deassertion is ignored; IDLE is held.

## Configuration
- `HARVARD_SEQ_CALL_EN` defined:
  - Adds an 8-bit return register.
  - CALL: ret=PC+1 (wrapping), PC=addr.
  - RET: PC=ret.
  - One level only; a nested CALL overwrites ret.
- Not defined: 0x0C and 0x0D are illegal opcodes (`illegal`=1, HALT); no return register is instantiated.

## Test plan
- Reset then `start`, program LDI 0x1234; STA 0x10; HALT → `DWE` high with `DWA`=0x10, `DW`=0x1234 in cycle 6; `halted`=1 after 9 cycles; `PC`=2.
- A=0xFFFF, M[0x20]=0x0001, ADD 0x20; JC 0x30 → A=0x0000, EF=1, CF=1; `PC`=0x30 after the JC.
- A=0x0003, SUB with M=0x0005 → A=0xFFFE, CF=1, EF=0. Then JZ 0x40 is not taken: `PC` increments.
- JMP 0xFF, NOP at 0xFF → `PC` wraps to 0x00 after the NOP.
- Opcode 0x2A → `illegal`=1 and `halted`=1, no write enable ever asserted. Then `RST_N` low for one edge → every output at its reset value and state IDLE.
- With `HARVARD_SEQ_CALL_EN`: CALL 0x50 at 0x07, RET at 0x50 → `PC` sequence 0x07, 0x50, 0x08. Without the macro: the same program halts at 0x07 with `illegal`=1.

Source files
------------

// File: rtl/harvard_sequencer_if.sv
// Memory-side bus of harvard_sequencer: instruction fetch, data memory,
// accumulator and status-flag signals. The sequencer is the master; the
// surrounding memory block is the slave.
interface harvard_sequencer_if;
    logic [7:0]  PC;
    logic [21:0] I;
    logic [7:0]  DWA;
    logic [15:0] DW;
    logic        DWE;
    logic [15:0] DR;
    logic [15:0] AW;
    logic        AWE;
    logic [15:0] AR;
    logic        EFW;
    logic        CFW;
    logic        EFF;
    logic        CFF;

    modport master (
        output PC, DWA, DW, DWE, AW, AWE, EFW, CFW,
        input  I, DR, AR, EFF, CFF
    );

    modport slave (
        input  PC, DWA, DW, DWE, AW, AWE, EFW, CFW,
        output I, DR, AR, EFF, CFF
    );
endinterface

// File: rtl/harvard_sequencer.sv
// harvard_sequencer: multi-cycle FETCH/DECODE/EXEC controller with a 16-bit
// ALU for the Harvard machine. Every instruction takes three cycles.
// Optional feature macro: HARVARD_SEQ_CALL_EN adds a one-level CALL/RET
// return register; without it opcodes 0x0C/0x0D are treated as illegal.
module harvard_sequencer (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    harvard_sequencer_if.master bus,
    output logic                halted,
    output logic                illegal
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_LDI  = 6'h01;
    localparam logic [5:0] OP_LDA  = 6'h02;
    localparam logic [5:0] OP_STA  = 6'h03;
    localparam logic [5:0] OP_ADD  = 6'h04;
    localparam logic [5:0] OP_SUB  = 6'h05;
    localparam logic [5:0] OP_AND  = 6'h06;
    localparam logic [5:0] OP_JMP  = 6'h08;
    localparam logic [5:0] OP_JZ   = 6'h09;
    localparam logic [5:0] OP_JC   = 6'h0A;
`ifdef HARVARD_SEQ_CALL_EN
    localparam logic [5:0] OP_CALL = 6'h0C;
    localparam logic [5:0] OP_RET  = 6'h0D;
`endif
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [2:0]  state_reg;
    logic [7:0]  pc_reg;
    logic [7:0]  dwa_reg;
    logic [21:0] ir_reg;
    logic        efw_reg;
    logic        cfw_reg;
    logic        illegal_reg;
    // Set by reset so that a start pulse on the first released edge is ignored.
    logic        start_block_reg;
`ifdef HARVARD_SEQ_CALL_EN
    logic [7:0]  ret_reg;
`endif

    logic [5:0]  opcode;
    logic [15:0] imm;
    logic [7:0]  target;
    logic [7:0]  pc_inc;
    logic [16:0] sum_wide;
    logic [16:0] diff_wide;
    logic        in_exec;

    assign opcode    = ir_reg[21:16];
    assign imm       = ir_reg[15:0];
    assign target    = ir_reg[7:0];
    assign pc_inc    = pc_reg + 8'd1;
    assign sum_wide  = {1'b0, bus.AR} + {1'b0, bus.DR};
    // Bit 16 of the 17-bit difference is the unsigned borrow.
    assign diff_wide = {1'b0, bus.AR} - {1'b0, bus.DR};
    assign in_exec   = (state_reg == ST_EXEC);

    logic [15:0] alu_result;
    logic        alu_carry;
    logic        acc_write;
    logic        mem_write;
    logic        flag_write;
    logic        op_legal;
    logic        op_halt;
    logic [7:0]  pc_next;

    // Decode the latched instruction into ALU result, enables and next PC.
    always_comb begin
        alu_result = 16'h0000;
        alu_carry  = cfw_reg;
        acc_write  = 1'b0;
        mem_write  = 1'b0;
        flag_write = 1'b0;
        op_legal   = 1'b1;
        op_halt    = 1'b0;
        pc_next    = pc_inc;
        case (opcode)
            OP_NOP: ;
            OP_LDI: begin
                alu_result = imm;
                acc_write  = 1'b1;
                flag_write = 1'b1;
            end
            OP_LDA: begin
                alu_result = bus.DR;
                acc_write  = 1'b1;
                flag_write = 1'b1;
            end
            OP_STA: mem_write = 1'b1;
            OP_ADD: begin
                alu_result = sum_wide[15:0];
                alu_carry  = sum_wide[16];
                acc_write  = 1'b1;
                flag_write = 1'b1;
            end
            OP_SUB: begin
                alu_result = diff_wide[15:0];
                alu_carry  = diff_wide[16];
                acc_write  = 1'b1;
                flag_write = 1'b1;
            end
            OP_AND: begin
                alu_result = bus.AR & bus.DR;
                alu_carry  = 1'b0;
                acc_write  = 1'b1;
                flag_write = 1'b1;
            end
            OP_JMP: pc_next = target;
            OP_JZ:  if (bus.EFF) pc_next = target;
            OP_JC:  if (bus.CFF) pc_next = target;
`ifdef HARVARD_SEQ_CALL_EN
            OP_CALL: pc_next = target;
            OP_RET:  pc_next = ret_reg;
`endif
            OP_HALT: op_halt = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Write enables and data exist only during EXEC; zero elsewhere.
    assign bus.PC  = pc_reg;
    assign bus.DWA = dwa_reg;
    assign bus.DWE = in_exec && mem_write;
    assign bus.DW  = (in_exec && mem_write) ? bus.AR : 16'h0000;
    assign bus.AWE = in_exec && acc_write;
    assign bus.AW  = (in_exec && acc_write) ? alu_result : 16'h0000;
    assign bus.EFW = efw_reg;
    assign bus.CFW = cfw_reg;
    assign halted  = (state_reg == ST_HALT);
    assign illegal = illegal_reg;

    // Sequencer state, PC, instruction register and flag registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= 8'h00;
            dwa_reg         <= 8'h00;
            ir_reg          <= 22'h0;
            efw_reg         <= 1'b0;
            cfw_reg         <= 1'b0;
            illegal_reg     <= 1'b0;
            start_block_reg <= 1'b1;
`ifdef HARVARD_SEQ_CALL_EN
            ret_reg         <= 8'h00;
`endif
        end else begin
            start_block_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    pc_reg <= 8'h00;
                    if (start && !start_block_reg) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: state_reg <= ST_DECODE;
                ST_DECODE: begin
                    ir_reg    <= bus.I;
                    dwa_reg   <= bus.I[7:0];
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!op_legal) begin
                        illegal_reg <= 1'b1;
                        state_reg   <= ST_HALT;
                    end else if (op_halt) begin
                        state_reg <= ST_HALT;
                    end else begin
                        pc_reg <= pc_next;
                        if (flag_write) begin
                            efw_reg <= (alu_result == 16'h0000);
                            cfw_reg <= alu_carry;
                        end
`ifdef HARVARD_SEQ_CALL_EN
                        if (opcode == OP_CALL) begin
                            ret_reg <= pc_inc;
                        end
`endif
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harvard_sequencer.sv
// Testbench for harvard_sequencer: memory environment plus an
// instruction-level reference model; directed programs then random programs.
module tb_harvard_sequencer;

    logic CLK;
    logic RST_N;
    logic start;
    logic halted;
    logic illegal;

    harvard_sequencer_if bus ();

    harvard_sequencer dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .bus     (bus),
        .halted  (halted),
        .illegal (illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment memories
    logic [21:0] imem [256];
    logic [15:0] dmem [256];
    logic [15:0] acc_mem = 16'h0000;
    logic        eff_reg = 1'b0;
    logic        cff_reg = 1'b0;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    assign bus.I   = imem[bus.PC];
    assign bus.DR  = dmem[bus.DWA];
    assign bus.AR  = acc_mem;
    assign bus.EFF = eff_reg;
    assign bus.CFF = cff_reg;

    always @(posedge CLK) begin
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (bus.DWE) dmem[bus.DWA] <= bus.DW;
        if (bus.AWE) acc_mem <= bus.AW;
        eff_reg <= bus.EFW;
        cff_reg <= bus.CFW;
    end

    // Reference model state (instruction level)
    int m_pc, m_a, m_ef, m_cf, m_ret, m_ill, m_halt;
    int m_dmem [256];
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic poke(input int a, input int d);
        pre_addr = a[7:0];
        pre_data = d[15:0];
        pre_we = 1'b1;
        @(negedge CLK);
        pre_we = 1'b0;
        m_dmem[a] = d;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = {6'h3F, 16'h0000};
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        m_pc = 0; m_ef = 0; m_cf = 0; m_ret = 0; m_ill = 0; m_halt = 0;
    endtask

    task automatic check_reset();
        chk("rst_pc", bus.PC, 0);
        chk("rst_dwa", bus.DWA, 0);
        chk("rst_dw", bus.DW, 0);
        chk("rst_aw", bus.AW, 0);
        chk("rst_en", {bus.DWE, bus.AWE}, 0);
        chk("rst_flags", {bus.EFW, bus.CFW}, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
    endtask

    task automatic do_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Run one instruction on the model and check the DUT through its three cycles.
    task automatic exec_one();
        logic [21:0] ins;
        int op, imm, ad, mv, a_old, npc, s;
        int e_dwe, e_awe, e_aw, e_dw;
        ins = imem[m_pc];
        op = int'(ins[21:16]);
        imm = int'(ins[15:0]);
        ad = int'(ins[7:0]);
        mv = m_dmem[ad];
        a_old = m_a;
        npc = (m_pc + 1) % 256;
        e_dwe = 0; e_awe = 0; e_aw = 0; e_dw = 0;
        case (op)
            0: ;
            1: begin m_a = imm; e_awe = 1; m_ef = (m_a == 0); end
            2: begin m_a = mv; e_awe = 1; m_ef = (m_a == 0); end
            3: begin e_dwe = 1; e_dw = a_old; m_dmem[ad] = a_old; end
            4: begin
                s = a_old + mv;
                m_cf = (s > 65535);
                m_a = s % 65536; e_awe = 1; m_ef = (m_a == 0);
            end
            5: begin
                m_cf = (a_old < mv);
                m_a = (a_old + 65536 - mv) % 65536; e_awe = 1; m_ef = (m_a == 0);
            end
            6: begin m_a = a_old & mv; m_cf = 0; e_awe = 1; m_ef = (m_a == 0); end
            8: npc = ad;
            9: if (m_ef != 0) npc = ad;
            10: if (m_cf != 0) npc = ad;
`ifdef HARVARD_SEQ_CALL_EN
            12: begin m_ret = (m_pc + 1) % 256; npc = ad; end
            13: npc = m_ret;
`endif
            63: m_halt = 1;
            default: begin m_halt = 1; m_ill = 1; end
        endcase
        e_aw = m_a;
        // FETCH
        chk("fetch_pc", bus.PC, m_pc);
        chk("fetch_en", {bus.DWE, bus.AWE}, 0);
        @(negedge CLK);
        // DECODE
        chk("decode_en", {bus.DWE, bus.AWE}, 0);
        @(negedge CLK);
        // EXEC
        chk("exec_dwa", bus.DWA, ad);
        chk("exec_dwe", bus.DWE, e_dwe);
        chk("exec_awe", bus.AWE, e_awe);
        if (e_dwe != 0) chk("exec_dw", bus.DW, e_dw);
        if (e_awe != 0) chk("exec_aw", bus.AW, e_aw);
        @(negedge CLK);
        // Following FETCH (or HALT)
        if (m_halt == 0) m_pc = npc;
        chk("post_pc", bus.PC, m_pc);
        chk("post_efw", bus.EFW, m_ef);
        chk("post_cfw", bus.CFW, m_cf);
        chk("post_acc", acc_mem, m_a);
        chk("post_halted", halted, m_halt);
        chk("post_illegal", illegal, m_ill);
        $display("instr op=%02h imm=%04h -> pc=%02h A=%04h EF=%0d CF=%0d halt=%0d ill=%0d",
                 op, imm, m_pc, m_a, m_ef, m_cf, m_halt, m_ill);
    endtask

    task automatic run_prog(input int max_instr);
        for (int k = 0; k < max_instr && m_halt == 0; k++) exec_one();
    endtask

    initial begin
        logic [5:0] rop;
        logic [15:0] rim;
        int r;
        RST_N = 1'b0;
        start = 1'b0;
        pre_we = 1'b0;
        pre_addr = 8'h00;
        pre_data = 16'h0000;
        m_a = 0; m_pc = 0; m_ef = 0; m_cf = 0; m_ret = 0; m_ill = 0; m_halt = 0;
        fill_halt();
        @(negedge CLK);
        for (int i = 0; i < 256; i++) poke(i, int'($urandom_range(0, 65535)));
        check_reset();

        // Test 1: LDI 0x1234; STA 0x10; HALT, with start on reset release ignored
        imem[0] = {6'h01, 16'h1234};
        imem[1] = {6'h03, 16'h0010};
        RST_N = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        chk("ignored_start_pc", bus.PC, 0);
        chk("ignored_start_acc", acc_mem, m_a);
        chk("ignored_start_halted", halted, 0);
        do_start();
        run_prog(5);

        // Test 2: A=FFFF + M=0001 -> carry, zero; JC taken
        do_reset();
        check_reset();
        fill_halt();
        poke(8'h20, 16'h0001);
        imem[0] = {6'h01, 16'hFFFF};
        imem[1] = {6'h04, 16'h0020};
        imem[2] = {6'h0A, 16'h0030};
        do_start();
        run_prog(6);

        // Test 3: 3 - 5 -> borrow, nonzero; JZ not taken
        do_reset();
        fill_halt();
        poke(8'h21, 16'h0005);
        imem[0] = {6'h01, 16'h0003};
        imem[1] = {6'h05, 16'h0021};
        imem[2] = {6'h09, 16'h0040};
        do_start();
        run_prog(6);

        // Test 4: JMP 0xFF; NOP at 0xFF wraps PC to 0x00
        do_reset();
        fill_halt();
        imem[0] = {6'h08, 16'h00FF};
        imem[255] = {6'h00, 16'h0000};
        do_start();
        run_prog(2);

        // Test 5: illegal opcode 0x2A, then reset
        do_reset();
        fill_halt();
        imem[0] = {6'h2A, 16'h0055};
        do_start();
        run_prog(2);
        repeat (3) @(negedge CLK);
        chk("halt_hold_en", {bus.DWE, bus.AWE}, 0);
        chk("halt_hold_pc", bus.PC, 0);
        chk("halt_hold_halted", halted, 1);
        do_reset();
        check_reset();

        // Test 6: CALL 0x50 at 0x07, RET at 0x50
        fill_halt();
        for (int i = 0; i < 7; i++) imem[i] = {6'h00, 16'h0000};
        imem[7] = {6'h0C, 16'h0050};
        imem[8'h50] = {6'h0D, 16'h0000};
        do_start();
        run_prog(12);

        // Random programs
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                r = int'($urandom_range(0, 19));
                rim = 16'($urandom);
                if (r < 3) rop = 6'h01;
                else if (r < 5) rop = 6'h02;
                else if (r < 7) rop = 6'h03;
                else if (r < 10) rop = 6'h04;
                else if (r < 12) rop = 6'h05;
                else if (r < 13) rop = 6'h06;
                else if (r < 14) rop = 6'h08;
                else if (r < 16) rop = 6'h09;
                else if (r < 18) rop = 6'h0A;
                else if (r < 19) rop = 6'h00;
                else rop = 6'($urandom_range(0, 63));
                imem[i] = {rop, rim};
            end
            do_start();
            run_prog(30);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
